// File: rtl/ifm_chunk_sparse_enc.sv
// ifm_chunk_sparse_enc
// --------------------
// Producer-side encoder for the double-buffered IFM sparse chunk store.
// Each accepted dense beat is compressed into a sparsemap (bit k set when
// lane k is nonzero) plus the nonzero bytes left-packed in ascending lane
// order. The write port alternates between two banks, one chunk
// (WR_DAT_CYC_NUM beats) per bank. A bank is never overwritten while it
// still holds a complete chunk that the reader has not released.
//
// Optional feature macro: IFM_ENC_NNZ_CNT_EN
//   When defined, adds nnz_cnt_o, the nonzero-byte total of the last
//   completed chunk.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous reset, active-low
//   in_data_i          dense beat, lane k = byte k
//   in_valid_i         beat offered
//   in_ready_o         beat accepted when in_valid_i && in_ready_o
//   flush_i            abort the partial chunk (offered beat is dropped)
//   rd_release_i       per-bank pulse: reader is done with that bank
//   wr_sparsemap_o     nonzero-lane map of the written beat
//   wr_nonzero_data_o  nonzero bytes packed from lane 0, rest zero
//   wr_valid_o         write strobe
//   wr_count_o         beat index within the chunk
//   wr_sel_o           target bank
//   bank_full_o        bank holds a complete, unreleased chunk
//   chunk_done_o       pulse with the last beat of a chunk
//   nnz_cnt_o          (IFM_ENC_NNZ_CNT_EN only) nonzero count of last chunk

`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 32
`endif

module ifm_chunk_sparse_enc #(
  parameter int BUS_SIZE = `BUS_SIZE,
  parameter int MEM_SIZE = `MEM_SIZE,
  localparam int WR_DAT_CYC_NUM = MEM_SIZE / BUS_SIZE,
  localparam int CNT_W = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1,
  localparam int POP_W = $clog2(BUS_SIZE + 1),
  localparam int NNZ_W = $clog2(MEM_SIZE) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BUS_SIZE*8-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  input  logic [1:0]            rd_release_i,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic                  wr_sel_o,
  output logic [1:0]            bank_full_o,
  output logic                  chunk_done_o
`ifdef IFM_ENC_NNZ_CNT_EN
  ,
  output logic [NNZ_W-1:0]      nnz_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WR_DAT_CYC_NUM - 1);

  typedef enum logic [0:0] {
    ST_FILL    = 1'b0,
    ST_BLOCKED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [BUS_SIZE-1:0]   wr_sparsemap_q, wr_sparsemap_d;
  logic [BUS_SIZE*8-1:0] wr_nonzero_data_q, wr_nonzero_data_d;
  logic [CNT_W-1:0]      wr_count_q, wr_count_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  chunk_done_q, chunk_done_d;

  logic [BUS_SIZE-1:0]   sparsemap_s;
  logic [BUS_SIZE*8-1:0] packed_s;
  logic [POP_W-1:0]      pos_s;
  logic [POP_W-1:0]      popcnt_s;
  logic                  accept_s;
  logic                  last_s;

  // Ready is a pure decode of the registered state, never of in_valid_i.
  assign in_ready_o = (state_q == ST_FILL);

  // Compaction: pos_s is the running prefix sum of sparsemap bits, i.e.
  // the destination slot of the next nonzero lane; its final value is the
  // popcount of the beat.
  always_comb begin
    sparsemap_s = '0;
    packed_s    = '0;
    pos_s       = '0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (in_data_i[8*k +: 8] != 8'h00) begin
        sparsemap_s[k]                 = 1'b1;
        packed_s[8*int'(pos_s) +: 8]   = in_data_i[8*k +: 8];
        pos_s                          = pos_s + POP_W'(1);
      end else begin
        sparsemap_s[k] = 1'b0;
      end
    end
    popcnt_s = pos_s;
  end

  // Beat handshake qualifiers; flush drops any beat offered with it.
  always_comb begin
    accept_s = in_valid_i && in_ready_o && !flush_i;
    last_s   = (cnt_q == LAST_CNT);
  end

  // Chunk sequencing, bank occupancy and write-port next values.
  always_comb begin
    cnt_d             = cnt_q;
    sel_d             = sel_q;
    wr_valid_d        = 1'b0;
    chunk_done_d      = 1'b0;
    wr_sparsemap_d    = wr_sparsemap_q;
    wr_nonzero_data_d = wr_nonzero_data_q;
    wr_count_d        = wr_count_q;
    wr_sel_d          = wr_sel_q;
    // Releasing a bank that is not full is a no-op by construction.
    bank_full_d       = bank_full_q & ~rd_release_i;

    if (flush_i) begin
      cnt_d = '0;
    end else if (accept_s) begin
      wr_valid_d        = 1'b1;
      wr_sparsemap_d    = sparsemap_s;
      wr_nonzero_data_d = packed_s;
      wr_count_d        = cnt_q;
      wr_sel_d          = sel_q;
      if (last_s) begin
        cnt_d              = '0;
        bank_full_d[sel_q] = 1'b1;
        sel_d              = ~sel_q;
        chunk_done_d       = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM next state: block whenever the bank to be written next is occupied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (bank_full_d[sel_d]) begin
          state_d = ST_BLOCKED;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_BLOCKED: begin
        if (!bank_full_d[sel_q]) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_BLOCKED;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q           <= ST_FILL;
      cnt_q             <= '0;
      sel_q             <= 1'b0;
      bank_full_q       <= 2'b00;
      wr_valid_q        <= 1'b0;
      wr_sparsemap_q    <= '0;
      wr_nonzero_data_q <= '0;
      wr_count_q        <= '0;
      wr_sel_q          <= 1'b0;
      chunk_done_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      sel_q             <= sel_d;
      bank_full_q       <= bank_full_d;
      wr_valid_q        <= wr_valid_d;
      wr_sparsemap_q    <= wr_sparsemap_d;
      wr_nonzero_data_q <= wr_nonzero_data_d;
      wr_count_q        <= wr_count_d;
      wr_sel_q          <= wr_sel_d;
      chunk_done_q      <= chunk_done_d;
    end
  end

  assign wr_valid_o        = wr_valid_q;
  assign wr_sparsemap_o    = wr_sparsemap_q;
  assign wr_nonzero_data_o = wr_nonzero_data_q;
  assign wr_count_o        = wr_count_q;
  assign wr_sel_o          = wr_sel_q;
  assign bank_full_o       = bank_full_q;
  assign chunk_done_o      = chunk_done_q;

`ifdef IFM_ENC_NNZ_CNT_EN
  logic [NNZ_W-1:0] nnz_acc_q, nnz_acc_d;
  logic [NNZ_W-1:0] nnz_cnt_q, nnz_cnt_d;
  logic [NNZ_W-1:0] nnz_sum_s;

  // Nonzero accumulator: the completing beat's popcount is folded into the
  // published total directly, so the accumulator can restart at zero.
  always_comb begin
    nnz_acc_d = nnz_acc_q;
    nnz_cnt_d = nnz_cnt_q;
    nnz_sum_s = nnz_acc_q + NNZ_W'(popcnt_s);
    if (flush_i) begin
      nnz_acc_d = '0;
    end else if (accept_s) begin
      if (last_s) begin
        nnz_cnt_d = nnz_sum_s;
        nnz_acc_d = '0;
      end else begin
        nnz_acc_d = nnz_sum_s;
      end
    end else begin
      nnz_acc_d = nnz_acc_q;
    end
  end

  // Nonzero-count registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      nnz_acc_q <= '0;
      nnz_cnt_q <= '0;
    end else begin
      nnz_acc_q <= nnz_acc_d;
      nnz_cnt_q <= nnz_cnt_d;
    end
  end

  assign nnz_cnt_o = nnz_cnt_q;
`endif

endmodule

// File: tb/tb_ifm_chunk_sparse_enc.sv
// Self-checking bench for ifm_chunk_sparse_enc (BUS_SIZE=8, MEM_SIZE=32,
// four beats per chunk). A transaction-level model tracks beat count,
// bank select and bank occupancy and compresses beats with a queue; a
// compare process checks the DUT against it every cycle, and directed
// steps add hand-computed literal expectations.
module tb_ifm_chunk_sparse_enc;

  localparam int BUS = 8;
  localparam int MEM = 32;
  localparam int BEATS = MEM / BUS;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [63:0] in_data_i = 64'h0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        flush_i = 1'b0;
  logic [1:0]  rd_release_i = 2'b00;
  logic [7:0]  wr_sparsemap_o;
  logic [63:0] wr_nonzero_data_o;
  logic        wr_valid_o;
  logic [1:0]  wr_count_o;
  logic        wr_sel_o;
  logic [1:0]  bank_full_o;
  logic        chunk_done_o;
`ifdef IFM_ENC_NNZ_CNT_EN
  logic [5:0]  nnz_cnt_o;
`endif

  ifm_chunk_sparse_enc #(.BUS_SIZE(BUS), .MEM_SIZE(MEM)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .in_data_i         (in_data_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .flush_i           (flush_i),
    .rd_release_i      (rd_release_i),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .wr_valid_o        (wr_valid_o),
    .wr_count_o        (wr_count_o),
    .wr_sel_o          (wr_sel_o),
    .bank_full_o       (bank_full_o),
    .chunk_done_o      (chunk_done_o)
`ifdef IFM_ENC_NNZ_CNT_EN
    ,
    .nnz_cnt_o         (nnz_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  typedef struct {
    int          cnt;
    logic        sel;
    logic [1:0]  full;
    logic        valid;
    logic        done;
    logic [7:0]  smap;
    logic [63:0] nz;
    int          count;
    logic        wsel;
    int          acc;
    int          nnz;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.cnt = 0; r.sel = 1'b0; r.full = 2'b00; r.valid = 1'b0; r.done = 1'b0;
    r.smap = 8'h00; r.nz = 64'h0; r.count = 0; r.wsel = 1'b0;
    r.acc = 0; r.nnz = 0;
    return r;
  endfunction

  // One clock of the chunk-store protocol, stated in terms of whole beats.
  function automatic mdl_t mdl_step(mdl_t c, logic v, logic [63:0] d,
                                    logic f, logic [1:0] rel);
    mdl_t n = c;
    logic [7:0] q[$];
    logic ok = v && !c.full[c.sel] && !f;
    n.valid = ok;
    n.done  = 1'b0;
    n.full  = c.full & ~rel;
    if (f) begin
      n.cnt = 0;
      n.acc = 0;
    end else if (ok) begin
      n.smap = 8'h00;
      for (int k = 0; k < BUS; k++) begin
        if (d[8*k +: 8] != 8'h00) begin
          q.push_back(d[8*k +: 8]);
          n.smap[k] = 1'b1;
        end
      end
      n.nz = 64'h0;
      for (int i = 0; i < q.size(); i++) n.nz[8*i +: 8] = q[i];
      n.count = c.cnt;
      n.wsel  = c.sel;
      n.acc   = c.acc + q.size();
      if (c.cnt == BEATS - 1) begin
        n.cnt = 0;
        n.full[c.sel] = 1'b1;
        n.sel  = !c.sel;
        n.done = 1'b1;
        n.nnz  = n.acc;
        n.acc  = 0;
      end else begin
        n.cnt = c.cnt + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) m <= mdl_reset();
    else        m <= mdl_step(m, in_valid_i, in_data_i, flush_i, rd_release_i);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("m_ready", 64'(in_ready_o), 64'(!m.full[m.sel]));
      chk("m_valid", 64'(wr_valid_o), 64'(m.valid));
      chk("m_done", 64'(chunk_done_o), 64'(m.done));
      chk("m_full", 64'(bank_full_o), 64'(m.full));
      if (m.valid) begin
        chk("m_smap", 64'(wr_sparsemap_o), 64'(m.smap));
        chk("m_nz", wr_nonzero_data_o, m.nz);
        chk("m_count", 64'(wr_count_o), 64'(m.count));
        chk("m_sel", 64'(wr_sel_o), 64'(m.wsel));
      end
`ifdef IFM_ENC_NNZ_CNT_EN
      chk("m_nnz", 64'(nnz_cnt_o), 64'(m.nnz));
`endif
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic f, input logic [1:0] rel);
    in_valid_i   = v;
    in_data_i    = d;
    flush_i      = f;
    rd_release_i = rel;
    @(negedge clk_i);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    rst_i  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_valid", 64'(wr_valid_o), 64'd0);
    chk("rst_full", 64'(bank_full_o), 64'd0);
    chk("rst_nz", wr_nonzero_data_o, 64'h0);

    // Single sparse beat, then a dense one, then flush with a beat.
    step(1'b1, 64'h0009_0000_0700_0500, 1'b0, 2'b00);
    chk("single_smap", 64'(wr_sparsemap_o), 64'h4A);
    chk("single_nz", wr_nonzero_data_o, 64'h0000_0000_0009_0705);
    chk("single_cnt", 64'(wr_count_o), 64'd0);
    chk("single_sel", 64'(wr_sel_o), 64'd0);
    step(1'b1, 64'h1122_3344_5566_7788, 1'b0, 2'b00);
    chk("second_cnt", 64'(wr_count_o), 64'd1);
    step(1'b1, 64'h0000_0000_0000_00FF, 1'b1, 2'b00);
    chk("flush_drop", 64'(wr_valid_o), 64'd0);

    // Full chunk of all-0x01 beats into bank 0.
    for (int i = 0; i < BEATS; i++) begin
      step(1'b1, 64'h0101_0101_0101_0101, 1'b0, 2'b00);
      chk("chunk0_cnt", 64'(wr_count_o), 64'(i));
      chk("chunk0_sel", 64'(wr_sel_o), 64'd0);
    end
    chk("chunk0_done", 64'(chunk_done_o), 64'd1);
    chk("chunk0_full", 64'(bank_full_o), 64'b01);
    chk("chunk0_ready", 64'(in_ready_o), 64'd1);
`ifdef IFM_ENC_NNZ_CNT_EN
    chk("chunk0_nnz", 64'(nnz_cnt_o), 64'd32);
`endif

    // Bank 1 with no bubble; includes an all-zero beat.
    step(1'b1, 64'h0, 1'b0, 2'b00);
    chk("zero_valid", 64'(wr_valid_o), 64'd1);
    chk("zero_smap", 64'(wr_sparsemap_o), 64'h00);
    chk("zero_nz", wr_nonzero_data_o, 64'h0);
    chk("zero_sel", 64'(wr_sel_o), 64'd1);
    step(1'b1, 64'h0000_0000_0000_00AB, 1'b0, 2'b00);
    step(1'b1, 64'h8000_0000_0000_0001, 1'b0, 2'b00);
    step(1'b1, 64'hFF00_FF00_FF00_FF00, 1'b0, 2'b00);
    chk("alt_smap", 64'(wr_sparsemap_o), 64'hAA);
    chk("alt_nz", wr_nonzero_data_o, 64'h0000_0000_FFFF_FFFF);
    chk("both_full", 64'(bank_full_o), 64'b11);
    chk("both_ready", 64'(in_ready_o), 64'd0);

    // Ninth beat is held while blocked.
    repeat (3) step(1'b1, 64'h0000_0000_0000_0C00, 1'b0, 2'b00);
    chk("held_valid", 64'(wr_valid_o), 64'd0);
    step(1'b1, 64'h0000_0000_0000_0C00, 1'b0, 2'b01);
    chk("rel_ready", 64'(in_ready_o), 64'd1);
    chk("rel_full", 64'(bank_full_o), 64'b10);
    step(1'b1, 64'h0000_0000_0000_0C00, 1'b0, 2'b00);
    chk("held_valid2", 64'(wr_valid_o), 64'd1);
    chk("held_sel", 64'(wr_sel_o), 64'd0);
    chk("held_cnt", 64'(wr_count_o), 64'd0);
    chk("held_nz", wr_nonzero_data_o, 64'h0C);

    // Completion into bank 0 while bank 1 is released in the same cycle.
    step(1'b1, 64'h5, 1'b0, 2'b00);
    step(1'b1, 64'h5, 1'b0, 2'b00);
    step(1'b1, 64'h5, 1'b0, 2'b10);
    chk("simul_done", 64'(chunk_done_o), 64'd1);
    chk("simul_full", 64'(bank_full_o), 64'b01);
    chk("simul_ready", 64'(in_ready_o), 64'd1);
    // Release of a bank that is not full is ignored.
    step(1'b0, 64'h0, 1'b0, 2'b10);
    chk("ign_rel_full", 64'(bank_full_o), 64'b01);

    // Asynchronous reset in the middle of a chunk.
    step(1'b1, 64'h77, 1'b0, 2'b00);
    step(1'b1, 64'h77, 1'b0, 2'b00);
    in_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_valid", 64'(wr_valid_o), 64'd0);
    chk("arst_nz", wr_nonzero_data_o, 64'h0);
    chk("arst_smap", 64'(wr_sparsemap_o), 64'h0);
    chk("arst_cnt", 64'(wr_count_o), 64'd0);
    chk("arst_sel", 64'(wr_sel_o), 64'd0);
    chk("arst_full", 64'(bank_full_o), 64'd0);
    chk("arst_done", 64'(chunk_done_o), 64'd0);
    chk("arst_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    step(1'b1, 64'h33, 1'b0, 2'b00);
    chk("post_sel", 64'(wr_sel_o), 64'd0);
    chk("post_cnt", 64'(wr_count_o), 64'd0);
    step(1'b0, 64'h0, 1'b0, 2'b00);
    step(1'b0, 64'h0, 1'b0, 2'b00);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
